// File: rtl/uart_rx.sv
// 8N1-style serial receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with frame-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s;
    logic                 complete;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        sync1_d     = rx;
        sync2_d     = sync1_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    if (rx_s) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A finished word only displaces the held one if it is free or being taken now.
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames are driven bit by bit and the
// received words and error pulses are collected by a monitor for checking.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         total_cnt;
    int         bad_cnt;
    logic [7:0] got_q[$];
    int         fe_cnt;
    int         ov_cnt;
    int         valid_cycles;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge; the stimulus process only wakes 1ns after rising edges.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (out_valid) valid_cycles++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearScoreboard();
        got_q.delete();
        fe_cnt       = 0;
        ov_cnt       = 0;
        valid_cycles = 0;
    endtask

    function automatic logic [31:0] wordAt(input int i);
        return (got_q.size() > i) ? {24'h0, got_q[i]} : 32'hDEAD;
    endfunction

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        step(CPB);
        for (int b = 0; b < 8; b++) begin
            rx = data[b];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        clearScoreboard();
        rst       = 1'b0;
        rx        = 1'b1;
        out_ready = 1'b1;
        step(3);
        checkOutput("rst_valid", {31'h0, out_valid}, 0);
        checkOutput("rst_data", {24'h0, out_data}, 0);
        checkOutput("rst_busy", {31'h0, busy}, 0);
        checkOutput("rst_ferr", {31'h0, frame_err}, 0);
        checkOutput("rst_ovr", {31'h0, overrun}, 0);
        rst = 1'b1;
        step(5);

        $display("[TB] case 1: single frame 0xA5");
        clearScoreboard();
        applyStimulus(8'hA5, 1'b1);
        step(20);
        checkOutput("a5_count", got_q.size(), 1);
        checkOutput("a5_data", wordAt(0), 32'hA5);
        checkOutput("a5_valid_len", valid_cycles, 1);
        checkOutput("a5_ferr", fe_cnt, 0);
        checkOutput("a5_ovr", ov_cnt, 0);

        $display("[TB] case 2: 4-cycle glitch then 0x5A");
        clearScoreboard();
        rx = 1'b0;
        step(4);
        checkOutput("glitch_busy", {31'h0, busy}, 1);
        rx = 1'b1;
        for (int i = 0; i < 12 && busy; i++) step(1);
        checkOutput("glitch_idle", {31'h0, busy}, 0);
        step(10);
        checkOutput("glitch_words", got_q.size(), 0);
        checkOutput("glitch_ferr", fe_cnt, 0);
        applyStimulus(8'h5A, 1'b1);
        step(20);
        checkOutput("5a_count", got_q.size(), 1);
        checkOutput("5a_data", wordAt(0), 32'h5A);

        $display("[TB] case 3: bad stop bit, break, then 0x01");
        clearScoreboard();
        applyStimulus(8'h3C, 1'b0);
        step(100);
        checkOutput("break_ferr", fe_cnt, 1);
        checkOutput("break_words", got_q.size(), 0);
        checkOutput("break_busy", {31'h0, busy}, 1);
        rx = 1'b1;
        step(8);
        checkOutput("break_release", {31'h0, busy}, 0);
        applyStimulus(8'h01, 1'b1);
        step(20);
        checkOutput("01_data", wordAt(0), 32'h01);
        checkOutput("01_ferr", fe_cnt, 1);

        $display("[TB] case 4: stalled consumer, 0x11 then 0x22");
        clearScoreboard();
        out_ready = 1'b0;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        step(20);
        checkOutput("stall_valid", {31'h0, out_valid}, 1);
        checkOutput("stall_data", {24'h0, out_data}, 32'h11);
        checkOutput("stall_ovr", ov_cnt, 1);
        checkOutput("stall_ferr", fe_cnt, 0);
        out_ready = 1'b1;
        step(1);
        checkOutput("stall_drain", {31'h0, out_valid}, 0);
        checkOutput("stall_word", wordAt(0), 32'h11);
        checkOutput("stall_count", got_q.size(), 1);

        $display("[TB] case 5: back-to-back stream");
        clearScoreboard();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h80, 1'b1);
        step(20);
        checkOutput("stream_count", got_q.size(), 3);
        checkOutput("stream_w0", wordAt(0), 32'h00);
        checkOutput("stream_w1", wordAt(1), 32'hFF);
        checkOutput("stream_w2", wordAt(2), 32'h80);
        checkOutput("stream_err", fe_cnt + ov_cnt, 0);

        $display("[TB] case 6: reset during a frame");
        clearScoreboard();
        out_ready = 1'b0;
        applyStimulus(8'h33, 1'b1);
        step(10);
        checkOutput("pre_rst_data", {24'h0, out_data}, 32'h33);
        rx = 1'b0;
        step(CPB);
        for (int b = 0; b < 3; b++) begin
            rx = 1'b1;
            step(CPB);
        end
        checkOutput("pre_rst_busy", {31'h0, busy}, 1);
        rst = 1'b0;
        step(1);
        checkOutput("mid_rst_valid", {31'h0, out_valid}, 0);
        checkOutput("mid_rst_data", {24'h0, out_data}, 0);
        checkOutput("mid_rst_busy", {31'h0, busy}, 0);
        checkOutput("mid_rst_pulses", {30'h0, frame_err, overrun}, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        step(20);
        checkOutput("post_rst_pulses", fe_cnt + ov_cnt, 0);
        clearScoreboard();
        applyStimulus(8'h42, 1'b1);
        step(20);
        checkOutput("42_count", got_q.size(), 1);
        checkOutput("42_data", wordAt(0), 32'h42);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
